// File: rtl/dotclk_enable_gen_if.sv
// Signal bundle between the dot-clock timing block and its consumers.
// The master drives lock/increment controls; the slave returns resets and tick strobes.
interface dotclk_enable_gen_if #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 16
);
    logic                    locked_in;
    logic [NUM_CH*ACC_W-1:0] inc_in;
    logic [NUM_CH-1:0]       inc_load;
    logic [NUM_CH-1:0]       ch_enable;
    logic                    sys_reset_n;
    logic                    ready;
    logic [NUM_CH-1:0]       tick_out;

    modport master (
        output locked_in, inc_in, inc_load, ch_enable,
        input  sys_reset_n, ready, tick_out
    );

    modport slave (
        input  locked_in, inc_in, inc_load, ch_enable,
        output sys_reset_n, ready, tick_out
    );
endinterface

// File: rtl/dotclk_enable_gen.sv
// PLL-lock qualifier, synchronous-release reset sequencer and NUM_CH
// phase-accumulator clock-enable generators, all in the PLL output clock domain.

module dotclk_nco_lane #(
    parameter int               ACC_W     = 16,
    parameter logic [ACC_W-1:0] INC_RESET = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             run_cur,
    input  logic             run_nxt,
    input  logic             enable,
    input  logic             load,
    input  logic [ACC_W-1:0] inc_new,
    output logic             tick
);
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] acc;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            inc  <= INC_RESET;
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            // a load and a carry on the same edge: the sum below still sees the old inc
            if (load)
                inc <= inc_new;
            if (!run_nxt) begin
                acc  <= '0;
                tick <= 1'b0;
            end else if (run_cur && enable) begin
                {tick, acc} <= {1'b0, acc} + {1'b0, inc};
            end else begin
                tick <= 1'b0;
            end
        end
    end
endmodule

module dotclk_enable_gen #(
    parameter int               NUM_CH      = 2,
    parameter int               ACC_W       = 16,
    parameter int               LOCK_CYCLES = 64,
    parameter int               SYNC_STAGES = 2,
    parameter logic [ACC_W-1:0] INC_RESET   = {1'b1, {(ACC_W-1){1'b0}}}
) (
    input  logic                clock_in,
    input  logic                reset_n,
    dotclk_enable_gen_if.slave  bus
);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        COUNT     = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk_s;
    logic                   ready_q;
    logic                   rst_q;
    logic [NUM_CH-1:0]      tick;

    // locked_in is asynchronous; this chain is its only sampling point
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lk_s) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (LOCK_CYCLES == 1) ? RUN : COUNT;
                end
            end
            COUNT: begin
                if (!lk_s) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_LOCK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt_nxt == CNT_W'(LOCK_CYCLES))
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_LOCK;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    // decoded from the next state so the outputs move on the same edge as the FSM
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            rst_q   <= 1'b0;
        end else begin
            ready_q <= (state_nxt == RUN);
            rst_q   <= (state_nxt == RUN);
        end
    end

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_lane
            dotclk_nco_lane #(
                .ACC_W     (ACC_W),
                .INC_RESET (INC_RESET)
            ) u_lane (
                .clock_in (clock_in),
                .reset_n  (reset_n),
                .run_cur  (state == RUN),
                .run_nxt  (state_nxt == RUN),
                .enable   (bus.ch_enable[c]),
                .load     (bus.inc_load[c]),
                .inc_new  (bus.inc_in[c*ACC_W +: ACC_W]),
                .tick     (tick[c])
            );
        end
    endgenerate

    assign bus.ready       = ready_q;
    assign bus.sys_reset_n = rst_q;
    assign bus.tick_out    = tick;
endmodule
